// File: rtl/key_io_device.sv
// key_io_device: synchronises and debounces four KEY pins, exposing KDATA (key state) and KCTRL (status) on the CPU bus.
// Reads are combinational; define KEY_IRQ_EN to add the interrupt-enable bit and a registered irq output.
module key_io_device #(
  parameter int unsigned      DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_KDATA      = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
  parameter logic [15:0]      DEBOUNCE_CYCLES = 16'd50000,
  parameter bit               KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [DBITS-1:0] i_addr,
  input  logic             i_rd_en,
  input  logic             i_wr_en,
  input  logic [DBITS-1:0] i_data_in,
  input  logic [3:0]       i_key_raw,
  output logic [DBITS-1:0] o_data_out,
  output logic             o_hit
`ifdef KEY_IRQ_EN
  ,
  output logic             o_irq
`endif
);

  localparam logic [3:0]  RELEASED = KEY_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [15:0] CNT_LAST = DEBOUNCE_CYCLES - 16'd1;

  logic [3:0]       r_sync1, r_sync2, r_cand, r_stable;
  logic [15:0]      r_cnt;
  logic             r_ready, r_overrun, r_ie;
  logic             w_accept, w_kdata_rd, w_kctrl_wr, w_unused_din;
  logic [3:0]       w_key_state;
  logic [DBITS-1:0] w_kdata, w_kctrl;

  assign w_accept   = (r_sync2 == r_cand) && (r_cand != r_stable) && (r_cnt == CNT_LAST);
  assign w_kdata_rd = i_rd_en && (i_addr == ADDR_KDATA);
  assign w_kctrl_wr = i_wr_en && (i_addr == ADDR_KCTRL);
  assign w_unused_din = ^i_data_in;

  // The whole 4-bit vector must hold steady; any bounce restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= RELEASED;
      r_sync2  <= RELEASED;
      r_cand   <= RELEASED;
      r_stable <= RELEASED;
      r_cnt    <= 16'd0;
    end else begin
      r_sync1 <= i_key_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= 16'd0;
      end else if (r_cand != r_stable) begin
        if (r_cnt == CNT_LAST) begin
          r_stable <= r_cand;
          r_cnt    <= 16'd0;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end else begin
        r_cnt <= 16'd0;
      end
    end
  end

  // An accept beats a same-cycle KDATA read, so the reader never loses an event.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept && r_ready && !w_kdata_rd)
        r_overrun <= 1'b1;
      else if (w_kctrl_wr && !i_data_in[2])
        r_overrun <= 1'b0;
      if (w_accept)
        r_ready <= 1'b1;
      else if (w_kdata_rd)
        r_ready <= 1'b0;
    end
  end

`ifdef KEY_IRQ_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ie  <= 1'b0;
      o_irq <= 1'b0;
    end else begin
      if (w_kctrl_wr)
        r_ie <= i_data_in[8];
      o_irq <= r_ie & r_ready;
    end
  end
`else
  assign r_ie = 1'b0;
`endif

  assign w_key_state = KEY_ACTIVE_LOW ? ~r_stable : r_stable;

  always_comb begin
    w_kdata      = '0;
    w_kdata[3:0] = w_key_state;
    w_kctrl      = '0;
    w_kctrl[0]   = r_ready;
    w_kctrl[2]   = r_overrun;
    w_kctrl[8]   = r_ie;
    o_data_out   = '0;
    if (i_addr == ADDR_KDATA)
      o_data_out = w_kdata;
    else if (i_addr == ADDR_KCTRL)
      o_data_out = w_kctrl;
  end

  assign o_hit = (i_addr == ADDR_KDATA) || (i_addr == ADDR_KCTRL);

endmodule
